sar_search_ctrl: RTL



---
 rtl/sar_search_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/sar_search_ctrl.sv
// Successive-approximation search controller driving a magnitude comparator's B operand.
// Optional flag-consistency checking is enabled with `define SAR_CMP_CHECK_EN.
module sar_search_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cmp_e,
  input  logic             cmp_g,
  input  logic             cmp_l,
  output logic [WIDTH-1:0] guess,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             found,
  output logic             err
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  state_t           state, state_nx;
  logic [IW-1:0]    idx, idx_nx;
  logic [WIDTH-1:0] guess_nx, result_nx;
  logic [WIDTH-1:0] idx_bit, acc;
  logic             busy_nx, done_nx, found_nx;

  assign idx_bit = WIDTH'(1) << idx;
  // cmp_l is implied by neither E nor G; an all-zero sample therefore decodes as L
  assign acc     = cmp_g ? guess : (guess & ~idx_bit);

`ifdef SAR_CMP_CHECK_EN
  logic err_q, err_nx, flag_bad;
  assign flag_bad = !({cmp_e, cmp_g, cmp_l} inside {3'b100, 3'b010, 3'b001});
  assign err      = err_q;
`else
  assign err = 1'b0;
`endif

  always_comb begin
    state_nx  = state;
    idx_nx    = idx;
    guess_nx  = guess;
    result_nx = result;
    busy_nx   = busy;
    done_nx   = 1'b0;
    found_nx  = found;
`ifdef SAR_CMP_CHECK_EN
    err_nx    = err_q;
`endif
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx = SEARCH;
          guess_nx = WIDTH'(1) << (WIDTH - 1);
          idx_nx   = IW'(WIDTH - 1);
          busy_nx  = 1'b1;
          found_nx = 1'b0;
`ifdef SAR_CMP_CHECK_EN
          err_nx   = 1'b0;
`endif
        end
      end
      SEARCH: begin
`ifdef SAR_CMP_CHECK_EN
        if (flag_bad) begin
          state_nx  = DONE;
          result_nx = '0;
          found_nx  = 1'b0;
          err_nx    = 1'b1;
          busy_nx   = 1'b0;
          done_nx   = 1'b1;
        end else
`endif
        if (cmp_e) begin
          state_nx  = DONE;
          result_nx = guess;
          found_nx  = 1'b1;
          busy_nx   = 1'b0;
          done_nx   = 1'b1;
        end else if (idx == '0) begin
          state_nx  = DONE;
          result_nx = acc;
          found_nx  = 1'b0;
          busy_nx   = 1'b0;
          done_nx   = 1'b1;
        end else begin
          guess_nx = acc | (idx_bit >> 1);
          idx_nx   = idx - IW'(1);
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= IW'(WIDTH - 1);
      guess  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      found  <= 1'b0;
    end else begin
      state  <= state_nx;
      idx    <= idx_nx;
      guess  <= guess_nx;
      busy   <= busy_nx;
      done   <= done_nx;
      result <= result_nx;
      found  <= found_nx;
    end
  end

`ifdef SAR_CMP_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_nx;
  end
`endif

endmodule
